// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns MemRead/MemWrite into a req/gnt/rvalid data-memory
// access, aligning store data, extending load data and reporting exceptions.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic [1:0]  o_exc,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;
    localparam logic [7:0] LAST_COUNT   = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  count;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [1:0]  exc_q;

    logic        request;
    logic        illegal;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    assign request     = i_MemRead | i_MemWrite;
    assign timeout_hit = (count == LAST_COUNT);

    always_comb begin
        illegal = i_MemRead & i_MemWrite;
        case (i_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b100, 3'b101:         if (i_MemWrite) illegal = 1'b1;
            default:                ;
        endcase
        misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << i_addr[1:0];
                wdata_new = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << i_addr[1:0];
                wdata_new = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = i_dmem_rdata[{off_q, 3'b000} +: 8];
        lane_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_ext = {24'd0, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_ext = {16'd0, lane_half};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_stall    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    o_stall    = 1'b1;
                    state_next = (illegal || misaligned) ? DONE : REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (i_dmem_gnt)       state_next = we_q ? DONE : RSP;
                else if (timeout_hit) state_next = DONE;
            end
            RSP: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The timeout counter spans REQ and RSP together; a gnt/rvalid on the last count wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            exc_q    <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        count    <= 8'd0;
                        addr_q   <= {i_addr[31:2], 2'b00};
                        we_q     <= i_MemWrite;
                        be_q     <= i_MemWrite ? be_new : 4'd0;
                        wdata_q  <= i_MemWrite ? wdata_new : 32'd0;
                        funct3_q <= i_funct3;
                        off_q    <= i_addr[1:0];
                        exc_q    <= illegal    ? EXC_ILLEGAL  :
                                    misaligned ? EXC_MISALIGN : EXC_NONE;
                    end
                end
                REQ: begin
                    count <= count + 8'd1;
                    if (!i_dmem_gnt && timeout_hit) exc_q <= EXC_TIMEOUT;
                end
                RSP: begin
                    count <= count + 8'd1;
                    if (i_dmem_rvalid)    rdata_q <= load_ext;
                    else if (timeout_hit) exc_q   <= EXC_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    assign o_dmem_req    = (state == REQ);
    assign o_dmem_we     = o_dmem_req & we_q;
    assign o_dmem_be     = o_dmem_req ? be_q    : 4'd0;
    assign o_dmem_addr   = o_dmem_req ? addr_q  : 32'd0;
    assign o_dmem_wdata  = o_dmem_req ? wdata_q : 32'd0;
    assign o_exc         = (state == DONE) ? exc_q : EXC_NONE;
    assign o_rdata_valid = (state == DONE) && !we_q && (exc_q == EXC_NONE);
    assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: table of access vectors with a responding
// memory model, scoreboard queue, plus hand-written reset-in-RSP sequence.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic [1:0]  o_exc;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    always #5 i_clk = ~i_clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
        .o_exc(o_exc), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_be(o_dmem_be), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          gnt_dly;
        int          rv_dly;
        int          exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_daddr;
        logic [31:0] exp_dwdata;
        logic        exp_we;
        logic [1:0]  exp_exc;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        int          exp_stall;
    } vec_t;

    vec_t        vecs[19];
    vec_t        sb[$];
    int          n_applied = 0;
    int          n_miscompares = 0;
    logic [31:0] last_rdata = 32'd0;

    logic        ob_done;
    int          ob_stall;
    int          ob_req;
    logic [3:0]  ob_be;
    logic [31:0] ob_addr;
    logic [31:0] ob_wdata;
    logic        ob_we;
    logic [1:0]  ob_exc;
    logic        ob_valid;
    logic [31:0] ob_rdata;
    logic        post_valid;
    logic        post_stall;
    logic        post_req;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                                     input int gdly, input logic [3:0] be, input logic [31:0] daddr,
                                     input logic [31:0] dwdata);
        vec_t v;
        v = '{rd: 1'b0, wr: 1'b1, f3: f3, addr: addr, wdata: wdata, mem: 32'd0,
              gnt_dly: gdly, rv_dly: 0, exp_req: gdly + 1, exp_be: be, exp_daddr: daddr,
              exp_dwdata: dwdata, exp_we: 1'b1, exp_exc: 2'b00, exp_valid: 1'b0,
              exp_rdata: 32'd0, exp_stall: 2 + gdly};
        return v;
    endfunction

    function automatic vec_t mkLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] mem,
                                    input int gdly, input int rvdly, input logic [31:0] daddr,
                                    input logic [31:0] rdata);
        vec_t v;
        v = '{rd: 1'b1, wr: 1'b0, f3: f3, addr: addr, wdata: 32'h5A5A5A5A, mem: mem,
              gnt_dly: gdly, rv_dly: rvdly, exp_req: gdly + 1, exp_be: 4'b0000, exp_daddr: daddr,
              exp_dwdata: 32'd0, exp_we: 1'b0, exp_exc: 2'b00, exp_valid: 1'b1,
              exp_rdata: rdata, exp_stall: 2 + gdly + rvdly};
        return v;
    endfunction

    function automatic vec_t mkExc(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [1:0] exc);
        vec_t v;
        v = '{rd: rd, wr: wr, f3: f3, addr: addr, wdata: 32'h11223344, mem: 32'd0,
              gnt_dly: 0, rv_dly: 0, exp_req: 0, exp_be: 4'b0000, exp_daddr: 32'd0,
              exp_dwdata: 32'd0, exp_we: 1'b0, exp_exc: exc, exp_valid: 1'b0,
              exp_rdata: 32'd0, exp_stall: 1};
        return v;
    endfunction

    task automatic checkAllZero(input string tag);
        cmp({tag, ".stall"}, 32'(o_stall), 32'd0);
        cmp({tag, ".rdata"}, o_rdata, 32'd0);
        cmp({tag, ".rvalid"}, 32'(o_rdata_valid), 32'd0);
        cmp({tag, ".exc"}, 32'(o_exc), 32'd0);
        cmp({tag, ".req"}, 32'(o_dmem_req), 32'd0);
        cmp({tag, ".we"}, 32'(o_dmem_we), 32'd0);
        cmp({tag, ".be"}, 32'(o_dmem_be), 32'd0);
        cmp({tag, ".daddr"}, o_dmem_addr, 32'd0);
        cmp({tag, ".dwdata"}, o_dmem_wdata, 32'd0);
    endtask

    task automatic checkOutput(input int idx);
        vec_t  e;
        string t;
        t = $sformatf("v%0d", idx);
        if (sb.size() == 0) begin
            cmp({t, ".scoreboard"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        cmp({t, ".done"}, 32'(ob_done), 32'd1);
        if (!ob_done) return;
        cmp({t, ".stall_cycles"}, 32'(ob_stall), 32'(e.exp_stall));
        cmp({t, ".req_cycles"}, 32'(ob_req), 32'(e.exp_req));
        cmp({t, ".exc"}, 32'(ob_exc), 32'(e.exp_exc));
        cmp({t, ".rdata_valid"}, 32'(ob_valid), 32'(e.exp_valid));
        cmp({t, ".rdata"}, ob_rdata, e.exp_rdata);
        if (e.exp_req > 0) begin
            cmp({t, ".be"}, 32'(ob_be), 32'(e.exp_be));
            cmp({t, ".daddr"}, ob_addr, e.exp_daddr);
            cmp({t, ".we"}, 32'(ob_we), 32'(e.exp_we));
            if (e.exp_we) cmp({t, ".dwdata"}, ob_wdata, e.exp_dwdata);
        end
        cmp({t, ".valid_pulse"}, 32'(post_valid), 32'd0);
        cmp({t, ".idle_stall"}, 32'(post_stall), 32'd0);
        cmp({t, ".idle_req"}, 32'(post_req), 32'd0);
    endtask

    // Drives one access, plays the memory side, and records what the DUT did.
    task automatic applyStimulus(input vec_t v, input int idx);
        vec_t e;
        int   gnt_at;
        e = v;
        if (e.exp_valid) last_rdata = e.exp_rdata;
        else             e.exp_rdata = last_rdata;
        sb.push_back(e);

        @(negedge i_clk);
        i_MemRead  = v.rd;
        i_MemWrite = v.wr;
        i_funct3   = v.f3;
        i_addr     = v.addr;
        i_wdata    = v.wdata;
        #1;
        ob_done = 1'b0; ob_stall = 0; ob_req = 0; gnt_at = -1;
        ob_be = 4'd0; ob_addr = 32'd0; ob_wdata = 32'd0; ob_we = 1'b0;
        ob_exc = 2'd0; ob_valid = 1'b0; ob_rdata = 32'd0;
        for (int c = 0; c < 64 && !ob_done; c++) begin
            i_dmem_gnt    = 1'b0;
            i_dmem_rvalid = 1'b0;
            i_dmem_rdata  = 32'hBAD0BAD0;
            if (!o_stall) begin
                ob_done  = 1'b1;
                ob_exc   = o_exc;
                ob_valid = o_rdata_valid;
                ob_rdata = o_rdata;
            end else begin
                ob_stall++;
                if (o_dmem_req) begin
                    ob_req++;
                    ob_be    = o_dmem_be;
                    ob_addr  = o_dmem_addr;
                    ob_wdata = o_dmem_wdata;
                    ob_we    = o_dmem_we;
                    if (ob_req - 1 == v.gnt_dly) begin
                        i_dmem_gnt = 1'b1;
                        gnt_at     = c;
                    end
                end else if (gnt_at >= 0 && c - gnt_at == v.rv_dly) begin
                    i_dmem_rvalid = 1'b1;
                    i_dmem_rdata  = v.mem;
                end
                @(negedge i_clk);
                #1;
            end
        end
        i_MemRead  = 1'b0;
        i_MemWrite = 1'b0;
        @(negedge i_clk);
        #1;
        post_valid = o_rdata_valid;
        post_stall = o_stall;
        post_req   = o_dmem_req;
        checkOutput(idx);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t t;
        i_rst_n = 1'b0;
        i_MemRead = 1'b0; i_MemWrite = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_wdata = 32'd0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checkAllZero("reset");

        vecs[0]  = mkStore(3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 4'b1111, 32'h100, 32'hDEADBEEF);
        vecs[1]  = mkStore(3'b000, 32'h0000_0103, 32'h000000A5, 0, 4'b1000, 32'h100, 32'hA5A5A5A5);
        vecs[2]  = mkStore(3'b001, 32'h0000_0102, 32'h0000BEEF, 2, 4'b1100, 32'h100, 32'hBEEFBEEF);
        vecs[3]  = mkStore(3'b000, 32'h0000_0101, 32'h0000003C, 1, 4'b0010, 32'h100, 32'h3C3C3C3C);
        vecs[4]  = mkLoad(3'b000, 32'h0000_0102, 32'h12F03456, 0, 3, 32'h100, 32'hFFFFFFF0);
        vecs[5]  = mkLoad(3'b100, 32'h0000_0102, 32'h12F03456, 0, 1, 32'h100, 32'h000000F0);
        vecs[6]  = mkLoad(3'b001, 32'h0000_0102, 32'h12F03456, 0, 1, 32'h100, 32'h000012F0);
        vecs[7]  = mkLoad(3'b001, 32'h0000_0100, 32'h12348765, 0, 1, 32'h100, 32'hFFFF8765);
        vecs[8]  = mkLoad(3'b101, 32'h0000_0102, 32'hABCD0000, 0, 1, 32'h100, 32'h0000ABCD);
        vecs[9]  = mkLoad(3'b010, 32'h0000_0104, 32'h89ABCDEF, 1, 2, 32'h104, 32'h89ABCDEF);
        vecs[10] = mkLoad(3'b000, 32'h0000_0101, 32'h00007F00, 0, 1, 32'h100, 32'h0000007F);
        vecs[11] = mkExc(1'b1, 1'b0, 3'b010, 32'h0000_0106, 2'b01);
        vecs[12] = mkExc(1'b0, 1'b1, 3'b101, 32'h0000_0100, 2'b11);
        vecs[13] = mkExc(1'b1, 1'b1, 3'b010, 32'h0000_0100, 2'b11);
        vecs[14] = mkExc(1'b0, 1'b1, 3'b001, 32'h0000_0101, 2'b01);
        vecs[15] = mkExc(1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b11);
        t = mkLoad(3'b010, 32'h0000_0200, 32'h0, 0, 1, 32'h200, 32'h0);
        t.gnt_dly = -1; t.exp_req = TIMEOUT; t.exp_stall = TIMEOUT + 1;
        t.exp_exc = 2'b10; t.exp_valid = 1'b0;
        vecs[16] = t;
        vecs[17] = mkLoad(3'b010, 32'h0000_0200, 32'hCAFEF00D, TIMEOUT - 1, 1, 32'h200, 32'hCAFEF00D);
        vecs[18] = mkStore(3'b010, 32'h0000_0208, 32'h01020304, TIMEOUT - 1, 4'b1111, 32'h208, 32'h01020304);

        for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

        // Reset while a load sits in RSP, then a stray rvalid must be ignored.
        @(negedge i_clk);
        i_MemRead = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0300;
        @(negedge i_clk);
        #1;
        cmp("rst.req_before", 32'(o_dmem_req), 32'd1);
        i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        #1;
        i_dmem_gnt = 1'b0;
        i_MemRead  = 1'b0;
        cmp("rst.stall_in_rsp", 32'(o_stall), 32'd1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        checkAllZero("rst.after");
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h55555555;
        @(negedge i_clk);
        #1;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'd0;
        checkAllZero("rst.stray_rvalid");
        last_rdata = 32'd0;
        applyStimulus(mkLoad(3'b010, 32'h0000_0304, 32'h0F1E2D3C, 0, 1, 32'h304, 32'h0F1E2D3C), 100);

        cmp("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the decode/execute stage and the data-memory port.
- Takes the MemRead/MemWrite strobes from main control, funct3 and the ALU-computed address.
- Drives a req/gnt/rvalid data-memory handshake, generates byte enables, and aligns store data.
- Sign/zero-extends load data, stalls the pipeline for the whole access, and reports misaligned, illegal and bus-timeout exceptions.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ+RSP before the access is aborted with a bus-timeout exception (legal range 2..255).

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  reset
i_MemRead  input  1  load request from main control
i_MemWrite  input  1  store request from main control
i_funct3  input  3  access size/sign (RV32I load/store encoding)
i_addr  input  32  effective byte address from ALU
i_wdata  input  32  store data (rs2), LSB-aligned
o_stall  output  1  hold pipeline
o_rdata  output  32  extended load result
o_rdata_valid  output  1  o_rdata valid this cycle (1-cycle pulse)
o_exc  output  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal; valid only in DONE
o_dmem_req  output  1  memory request
o_dmem_we  output  1  1 = write
o_dmem_be  output  4  byte enables
o_dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  output  32  lane-replicated store data
i_dmem_gnt  input  1  request accepted this cycle
i_dmem_rvalid  input  1  read data valid
i_dmem_rdata  input  32  read data

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset is synchronous and active-low (i_rst_n sampled on the rising edge of i_clk).
  - Reset forces state IDLE, timeout counter 0, and all outputs 0 (o_dmem_* included), including mid-access; a pending gnt/rvalid is ignored.
- States: IDLE, REQ, RSP, DONE.
- IDLE:
  - A request is i_MemRead|i_MemWrite.
  - Both high, or an illegal funct3, -> DONE with o_exc=11. Illegal funct3 is 011, 110, 111 for either access type; 100 and 101 are also illegal for a store.
  - Misaligned -> DONE with o_exc=01, no bus request issued. Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - Otherwise latch aligned address, we, be, wdata, funct3 and addr[1:0], then go to REQ.
  - o_stall is combinationally 1 in IDLE whenever a request is present.
- REQ:
  - o_dmem_req=1, and address/we/be/wdata are held stable until i_dmem_gnt.
  - On gnt: a store goes to DONE, a load goes to RSP. req drops the cycle after gnt.
- RSP:
  - Wait for i_dmem_rvalid; rvalid is never sampled in the gnt cycle.
  - On rvalid, capture the extracted/extended data and go to DONE.
- DONE:
  - Lasts one cycle with o_stall=0, so the pipeline advances on this edge. Next state is IDLE.
  - Request inputs present in DONE belong to the retiring instruction and are ignored.
  - o_rdata_valid=1 only for a load that completed without exception. o_rdata holds its value until the next load completes.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RSP.
  - When count == TIMEOUT_CYCLES-1 and neither gnt (in REQ) nor rvalid (in RSP) occurs that cycle, go to DONE with o_exc=10 and no rdata_valid.
  - A gnt or rvalid in that same last cycle wins over the timeout.
- o_stall is 1 in REQ and RSP, and 0 in DONE and in IDLE when there is no request.
- Minimum latency:
  - Store: 3 cycles (IDLE, REQ with immediate gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, RSP with rvalid the next cycle, DONE).
- Byte enables and store data, with off = addr[1:0]:
  - SB (000): be = 0001<<off, wdata = byte replicated x4.
  - SH (001): be = 0011<<off, wdata = halfword replicated x2.
  - SW (010): be = 1111, wdata as-is.
  - be is 0 for loads; a load always reads the full word.
- Load extraction:
  - LB/LBU (000/100): rdata[8*off +: 8].
  - LH/LHU (001/101): rdata[16*off[1] +: 16].
  - LW (010): full word.
  - 000 and 001 sign-extend; 100 and 101 zero-extend.

Test Plan:
- SW at 0x100, data 0xDEADBEEF, gnt on first REQ cycle -> one req with be=1111, addr=0x100, wdata=0xDEADBEEF; stall is 1 for 2 cycles, then 0 in DONE; exc=00.
- SB to 0x103, data 0x000000A5 -> be=1000, addr=0x100, wdata=0xA5A5A5A5.
- LB from 0x102 with rdata=0x12F03456 and rvalid 3 cycles after gnt -> rdata=0xFFFFFFF0 with a 1-cycle rdata_valid. LBU at the same address -> 0x000000F0. LH from 0x102 -> 0x000012F0.
- LW from 0x106 -> no req, DONE with exc=01. SH with funct3=101 -> exc=11. MemRead and MemWrite both high -> exc=11.
- Load with gnt never asserted, TIMEOUT_CYCLES=16 -> req high for 16 cycles, then DONE with exc=10, rdata_valid=0, and IDLE the cycle after. Repeat with gnt exactly in the 16th cycle -> proceeds to RSP with no timeout.
- i_rst_n low for one edge while in RSP -> IDLE with all outputs 0. A subsequent rvalid is ignored, and a new LW completes normally.
